// File: rtl/dec_lut_encoder_clk.sv
`default_nettype none
// ============================================================================
// Module      : dec_lut_encoder_clk
// Description : Serial shift-add encoder, W = (N * MUL + OFS) mod 2^W_BITS.
//               Processes one bit of N per clock and uses a valid/ready
//               handshake on both the input and the output side.
// Revision    : 1.0 - initial release
// ============================================================================
module dec_lut_encoder_clk #(
    parameter int                         N_BITS = 31,
    parameter int                         W_BITS = 46,
    parameter logic [W_BITS-N_BITS-1:0]   MUL    = (W_BITS-N_BITS)'(32749),
    parameter logic [W_BITS-1:0]          OFS    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] N,
    output logic [W_BITS-1:0] W,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    // The counter only has to reach N_BITS-1, so it never wraps inside CALC.
    localparam int                 c_CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N_BITS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_HOLD = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [N_BITS-1:0]  r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic [W_BITS-1:0]  r_acc;
    logic [W_BITS-1:0]  r_w;
    logic               r_out_valid;

    logic [W_BITS-1:0]  w_mul_ext;
    logic [W_BITS-1:0]  w_addend;
    logic [W_BITS-1:0]  w_acc_sum;
    logic               w_last;

    assign w_mul_ext = {{N_BITS{1'b0}}, MUL};
    assign w_addend  = w_mul_ext << r_cnt;
    // Partial product for the current bit of N; carry-out beyond W_BITS is dropped.
    assign w_acc_sum = r_shreg[0] ? (r_acc + w_addend) : r_acc;
    assign w_last    = (r_cnt == c_LAST);

    // Handshake flags are plain decodes of the registered state.
    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);
    assign W         = r_w;
    assign out_valid = r_out_valid;

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_state_nxt = c_CALC;
            c_CALC:  if (w_last)    w_state_nxt = c_HOLD;
            c_HOLD:  if (out_ready) w_state_nxt = c_IDLE;
            default:                w_state_nxt = c_IDLE;
        endcase
    end

    // State register and shift-add datapath; W only updates on CALC->HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_w         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_shreg <= N;
                        r_acc   <= OFS;
                        r_cnt   <= '0;
                    end
                end
                c_CALC: begin
                    r_acc   <= w_acc_sum;
                    r_shreg <= r_shreg >> 1;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_w         <= w_acc_sum;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_HOLD: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dec_lut_encoder_clk.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec_lut_encoder_clk
// Description : Directed self-checking bench for dec_lut_encoder_clk, with a
//               second instance using an all-ones offset to exercise wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_lut_encoder_clk;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] N;
    logic [45:0] W;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic        in_ready2;
    logic [45:0] W2;
    logic        out_valid2;
    logic        busy2;

    int checks = 0;
    int errors = 0;

    dec_lut_encoder_clk u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .N(N),
        .W(W), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    dec_lut_encoder_clk #(.OFS(46'h3FFF_FFFF_FFFF)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .N(N),
        .W(W2), .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present n until accepted; returns once the accept edge has passed.
    task automatic send(input logic [30:0] n);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        N = n;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (in_ready) ok = 1;
            step();
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    // Count edges until out_valid rises; flags any W change before that.
    task automatic wait_out(output int lat, output bit w_moved);
        logic [45:0] w0;
        w0 = W;
        lat = 0;
        w_moved = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            lat++;
            if (out_valid) break;
            if (W !== w0) w_moved = 1;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    int          lat;
    bit          moved;
    bit          bad_ov;
    bit          bad_w;
    bit          bad_ir;
    logic [45:0] w_hold;
    int          cyc;
    int          acc_edges[$];
    int          nres;

    initial begin
        clk = 0; rst = 1; in_valid = 0; N = '0; out_ready = 1;
        step(); step();
        rst = 0;
        chk("rst_W", W, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // N = 0
        send(31'd0);
        chk("calc_busy", busy, 1);
        chk("calc_in_ready", in_ready, 0);
        wait_out(lat, moved);
        chk("lat_n0", lat, 31);
        chk("W_n0", W, 0);
        step();

        // N = 1, plus wrap instance with OFS = 2^46-1
        send(31'd1);
        wait_out(lat, moved);
        chk("lat_n1", lat, 31);
        chk("W_n1", W, 32749);
        chk("wrap_ov", out_valid2, 1);
        chk("wrap_W", W2, 32748);
        step();
        chk("hold_exit_ov", out_valid, 0);
        chk("hold_exit_W", W, 32749);

        // N = 2^30-1; W must not move during CALC
        send(31'd1073741823);
        wait_out(lat, moved);
        chk("lat_mid", lat, 31);
        chk("W_mid", W, 46'd35163970961427);
        chk("W_glitch_calc", moved, 0);
        step();

        // Max N
        send(31'h7FFF_FFFF);
        wait_out(lat, moved);
        chk("lat_max", lat, 31);
        chk("W_max", W, 46'd70327941955603);
        step();

        // Backpressure: hold 10 cycles with a pending N=5
        out_ready = 0;
        send(31'd1);
        wait_out(lat, moved);
        chk("bp_W0", W, 32749);
        w_hold = W;
        in_valid = 1; N = 31'd5;
        bad_ov = 0; bad_w = 0; bad_ir = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1) bad_ov = 1;
            if (W !== w_hold) bad_w = 1;
            if (in_ready !== 1'b0) bad_ir = 1;
        end
        chk("bp_ov_stable", bad_ov, 0);
        chk("bp_W_stable", bad_w, 0);
        chk("bp_in_ready_low", bad_ir, 0);
        out_ready = 1;
        step();
        chk("bp_idle_ov", out_valid, 0);
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_busy", busy, 0);
        step();
        in_valid = 0;
        chk("bp_accept_busy", busy, 1);
        wait_out(lat, moved);
        chk("lat_n5", lat, 31);
        chk("W_n5", W, 163745);
        step();

        // Reset mid-CALC aborts the result
        send(31'd1073741823);
        repeat (10) step();
        rst = 1;
        step(); step();
        rst = 0;
        chk("rst2_W", W, 0);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_in_ready", in_ready, 1);
        bad_ov = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0) bad_ov = 1;
        end
        chk("rst2_no_ov", bad_ov, 0);

        // Back-to-back stream with in_valid held high
        in_valid = 1; N = 31'd1073741823;
        cyc = 0; nres = 0;
        for (int i = 0; i < 140 && nres < 3; i++) begin
            if (in_ready && in_valid) acc_edges.push_back(cyc);
            step();
            cyc++;
            if (out_valid) begin
                chk($sformatf("b2b_W%0d", nres), W, 46'd35163970961427);
                nres++;
            end
        end
        in_valid = 0;
        chk("b2b_results", nres, 3);
        if (acc_edges.size() >= 3) begin
            chk("b2b_space1", acc_edges[1] - acc_edges[0], 33);
            chk("b2b_space2", acc_edges[2] - acc_edges[1], 33);
        end else begin
            chk("b2b_accepts", acc_edges.size(), 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dec_lut_encoder_clk.md
Name: dec_lut_encoder_clk

Overview:
Sequential encoder that maps a 31-bit index N to the 46-bit codeword W that the DEC_LUT decoder inverts: W = (N * MUL + OFS) mod 2^W_BITS.
- Computed by a serial shift-add engine, one bit of N per clock.
- Sits upstream of the decoder and generates its W stimulus / production codewords.
- Uses a valid/ready handshake on both sides so it can feed the decoder directly or be throttled by a consumer.

Parameters:
N_BITS, 31, index width.
W_BITS, 46, codeword width.
MUL, 32749, multiplier constant; width W_BITS-N_BITS (15 bits); must be nonzero.
OFS, 0, additive offset, W_BITS wide.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  N is presented.
in_ready  output  1  encoder can accept N (high only in IDLE).
N  input  N_BITS  index to encode; sampled on the accept edge only.
W  output  W_BITS  encoded codeword; valid while out_valid=1.
out_valid  output  1  W holds a finished result.
out_ready  input  1  consumer takes W.
busy  output  1  high in CALC or HOLD.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, W=0, out_valid=0, busy=0, in_ready=1, bit counter=0, accumulator=0. Reset overrides every other input. A reset mid-CALC or mid-HOLD discards the result; no out_valid pulse follows.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1, latch N into a shift register, set acc=OFS, set cnt=0, go to CALC.
  - CALC: in_ready=0. Each edge: if shreg[0]=1 then acc = acc + (MUL << cnt), truncated to W_BITS. Then shreg >>= 1 and cnt += 1. On the edge that processes cnt=N_BITS-1: W <= final acc, out_valid <= 1, go to HOLD. in_valid is ignored in CALC.
  - HOLD: W and out_valid held stable. On an edge with out_ready=1: out_valid <= 0, go to IDLE; W keeps its value. out_ready is ignored outside HOLD.
- Latency: fixed N_BITS edges from the accept edge to out_valid=1. There is no early termination for small N, so N=0 also takes 31 cycles.
- Throughput: at most one result per N_BITS+2 cycles. The next accept can occur on the edge after the HOLD->IDLE edge, because in_ready is a registered state decode.
- Arithmetic: all sums are modulo 2^W_BITS and overflow is silently dropped. With the defaults the maximum N gives 70327941955603, which is less than 2^46, so no wrap occurs.
- Counter: ceil(log2(N_BITS)) bits; it must not wrap inside CALC.
- W changes only on the CALC->HOLD edge or on reset. It never glitches during CALC.
- Simultaneous in_valid and out_ready in HOLD: only out_ready acts. in_valid is accepted no earlier than the following IDLE edge.

Test Plan:
1. Reset: hold rst=1 for 2 edges mid-CALC. Required: W=0, out_valid=0, busy=0, in_ready=1 at the first post-reset cycle, and no out_valid ever appears for the aborted input.
2. Basic values with out_ready tied to 1:
   - N=0 -> W=0.
   - N=1 -> W=32749.
   - N=1073741823 -> W=35163970961427.
   Each out_valid must rise exactly 31 edges after its accept edge.
3. Max input: N=2147483647 -> W=70327941955603. Check no truncation of the top bits.
4. Backpressure: out_ready=0 for 10 cycles after out_valid. Required:
   - W and out_valid are stable throughout.
   - in_ready stays 0.
   - A new in_valid with N=5 is not accepted until IDLE; it then yields W=163745.
5. Back-to-back: stream the file vectors (all N=1073741823) with in_valid held high and out_ready=1. Required:
   - Every W = 35163970961427.
   - Accept edges are spaced 33 cycles apart.
   - Feeding each W to DEC_LUT_Decoder30bits_clk returns found=1 and N=1073741823.
6. Wrap rule: instantiate with OFS = 2^46-1 and N=1. Required: W=32748 (the sum wraps modulo 2^46).
